// File: rtl/rca_ft_pkg.sv
// Shared types, vector table and reconfiguration encodings for the
// fault-tolerant ripple-carry adder BIST controller.
package rca_ft_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_APPLY,
        ST_SETTLE,
        ST_DECIDE,
        ST_CONFIG,
        ST_DONE
    } state_t;

    localparam int NUM_VEC = 10;

    typedef struct packed {
        logic [4:0] ta;
        logic [4:0] tb;
        logic       tc_1;
    } vec_t;

    typedef struct packed {
        logic [2:0] is_sel;
        logic [4:0] cs;
        logic [3:0] ss;
    } cfg_t;

    localparam cfg_t CFG_NORMAL = '{is_sel: 3'b000, cs: 5'b00000, ss: 4'b0000};
    // Routes the spare's sum onto s[3] and its carry onto s[4] for observation.
    localparam cfg_t CFG_TEST   = '{is_sel: 3'b000, cs: 5'b10000, ss: 4'b1000};

    function automatic vec_t vec_rom(input logic [3:0] i);
        vec_t v;
        case (i)
            4'd8:    v = '{ta: 5'b01010, tb: 5'b10101, tc_1: 1'b1};
            4'd9:    v = '{ta: 5'b10101, tb: 5'b01010, tc_1: 1'b0};
            default: v = '{ta: {5{i[0]}}, tb: {5{i[1]}}, tc_1: i[2]};
        endcase
        return v;
    endfunction

    // Shift inputs and sums up from slice k, bypass k's carry, take cout from the spare.
    function automatic cfg_t cfg_for_slice(input logic [1:0] k);
        cfg_t c;
        c = CFG_NORMAL;
        for (int m = 0; m < 3; m++) begin
            c.is_sel[m] = (m >= int'(k));
        end
        for (int m = 0; m < 4; m++) begin
            c.ss[m] = (m >= int'(k));
        end
        c.cs[k] = 1'b1;
        c.cs[4] = 1'b1;
        return c;
    endfunction

endpackage

// File: rtl/rca_ft_bist_ctrl_if.sv
// Test/reconfiguration bus between the BIST controller and the adder.
interface rca_ft_bist_ctrl_if;
    logic       test;
    logic       tc_1;
    logic [4:0] ta;
    logic [4:0] tb;
    logic [2:0] is;
    logic [4:0] cs;
    logic [3:0] ss;
    logic [3:0] st;
    logic [3:0] ct;
    logic [4:0] s_obs;

    modport master (
        output test, tc_1, ta, tb, is, cs, ss,
        input  st, ct, s_obs
    );

    modport slave (
        input  test, tc_1, ta, tb, is, cs, ss,
        output st, ct, s_obs
    );
endinterface

// File: rtl/rca_ft_slice_chk.sv
// Per-slice expected-vs-observed check; each slice's carry-in is the observed
// carry of the slice below, so a fault never masks or blames a neighbour.
module rca_ft_slice_chk (
    input  logic [4:0] ta,
    input  logic [4:0] tb,
    input  logic       tc_1,
    input  logic [3:0] st,
    input  logic [3:0] ct,
    input  logic [4:0] s_obs,
    output logic [4:0] mismatch
);
    logic [4:0] cin;
    logic [4:0] obs_s;
    logic [4:0] obs_c;
    logic [4:0] exp_s;
    logic [4:0] exp_c;

    assign cin   = {ct, tc_1};
    assign obs_s = {s_obs[3], st};
    assign obs_c = {s_obs[4], ct};
    assign exp_s = ta ^ tb ^ cin;
    assign exp_c = (ta & tb) | (ta & cin) | (tb & cin);

    assign mismatch = (exp_s ^ obs_s) | (exp_c ^ obs_c);
endmodule

// File: rtl/rca_ft_bist_ctrl.sv
// BIST and spare-slice reconfiguration controller for the 4+1 slice adder.
// start is level-sampled in IDLE/DONE only; all outputs are registered.
module rca_ft_bist_ctrl
    import rca_ft_pkg::*;
#(
    parameter int SETTLE_CYC = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    rca_ft_bist_ctrl_if.master        adder,
    output logic                      busy,
    output logic                      done,
    output logic [4:0]                fault_mask,
    output logic                      fail,
    output state_t                    dbg_state
);
    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYC - 1);
    localparam logic [3:0] LAST_VEC    = 4'(NUM_VEC - 1);

    state_t     state_q, state_d;
    logic [3:0] idx_q, idx_d;
    logic [7:0] cnt_q, cnt_d;
    logic       test_q, test_d;
    vec_t       vec_q, vec_d;
    cfg_t       cfg_q, cfg_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic [4:0] mask_q, mask_d;
    logic       fail_q, fail_d;

    logic [4:0] mismatch;
    logic       single;
    logic [1:0] k;

    rca_ft_slice_chk u_chk (
        .ta       (vec_q.ta),
        .tb       (vec_q.tb),
        .tc_1     (vec_q.tc_1),
        .st       (adder.st),
        .ct       (adder.ct),
        .s_obs    (adder.s_obs),
        .mismatch (mismatch)
    );

    // Exactly one faulty slice among 0..3 with a healthy spare.
    assign single = (mask_q[3:0] != 4'b0000) && ((mask_q & (mask_q - 5'd1)) == 5'd0);

    always_comb begin
        k = 2'd3;
        case (mask_q[3:0])
            4'b0001: k = 2'd0;
            4'b0010: k = 2'd1;
            4'b0100: k = 2'd2;
            default: k = 2'd3;
        endcase
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        test_d  = test_q;
        vec_d   = vec_q;
        cfg_d   = cfg_q;
        busy_d  = busy_q;
        done_d  = done_q;
        mask_d  = mask_q;
        fail_d  = fail_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_APPLY;
                    idx_d   = 4'd0;
                    mask_d  = 5'b00000;
                    fail_d  = 1'b0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    test_d  = 1'b1;
                    vec_d   = vec_rom(4'd0);
                    cfg_d   = CFG_TEST;
                end
            end
            ST_APPLY: begin
                state_d = ST_SETTLE;
                cnt_d   = 8'd0;
            end
            ST_SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    mask_d = mask_q | mismatch;
                    if (idx_q < LAST_VEC) begin
                        idx_d   = idx_q + 4'd1;
                        vec_d   = vec_rom(idx_q + 4'd1);
                        state_d = ST_APPLY;
                    end else begin
                        state_d = ST_DECIDE;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_DECIDE: begin
                state_d = ST_CONFIG;
                test_d  = 1'b0;
                vec_d   = '0;
                if (mask_q[3:0] == 4'b0000) begin
                    cfg_d = CFG_NORMAL;
                end else if (single) begin
                    cfg_d = cfg_for_slice(k);
                end else begin
                    cfg_d  = CFG_NORMAL;
                    fail_d = 1'b1;
                end
            end
            ST_CONFIG: begin
                state_d = ST_DONE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= 4'd0;
            cnt_q   <= 8'd0;
            test_q  <= 1'b0;
            vec_q   <= '0;
            cfg_q   <= CFG_NORMAL;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            mask_q  <= 5'b00000;
            fail_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            test_q  <= test_d;
            vec_q   <= vec_d;
            cfg_q   <= cfg_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            mask_q  <= mask_d;
            fail_q  <= fail_d;
        end
    end

    assign adder.test = test_q;
    assign adder.tc_1 = vec_q.tc_1;
    assign adder.ta   = vec_q.ta;
    assign adder.tb   = vec_q.tb;
    assign adder.is   = cfg_q.is_sel;
    assign adder.cs   = cfg_q.cs;
    assign adder.ss   = cfg_q.ss;

    assign busy       = busy_q;
    assign done       = done_q;
    assign fault_mask = mask_q;
    assign fail       = fail_q;
    assign dbg_state  = state_q;
endmodule

// File: tb/tb_rca_ft_bist_ctrl.sv
// Bench for rca_ft_bist_ctrl: a fault-injectable 4+1 slice adder model, a
// queue of expected BIST outcomes, and a monitor that checks each completion.
module tb_rca_ft_bist_ctrl;
    import rca_ft_pkg::*;

    localparam int SETTLE_CYC = 2;
    localparam int LATENCY    = NUM_VEC * (1 + SETTLE_CYC) + 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       busy;
    logic       done;
    logic       fail;
    logic [4:0] fault_mask;
    state_t     dbg_state;

    logic [3:0] a;
    logic [3:0] b;
    logic [4:0] s_en, s_val, c_en, c_val;

    int         cyc    = 0;
    int         n_cmp  = 0;
    int         n_fail = 0;
    logic [17:0] exp_q[$];
    int          acc_q[$];
    logic        done_prev = 1'b0;

    rca_ft_bist_ctrl_if bus();

    rca_ft_bist_ctrl #(.SETTLE_CYC(SETTLE_CYC)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .adder      (bus),
        .busy       (busy),
        .done       (done),
        .fault_mask (fault_mask),
        .fail       (fail),
        .dbg_state  (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running at %0t, required finish", $time);
        $fatal(1, "global timeout");
    end

    // ---------------- adder model with stuck-at faults ----------------
    function automatic logic [12:0] adder_eval(
        input logic test_i, tc_i,
        input logic [4:0] ta_i, tb_i,
        input logic [2:0] is_i,
        input logic [4:0] cs_i,
        input logic [3:0] ss_i,
        input logic [3:0] a_i, b_i,
        input logic [4:0] se, sv, ce, cv
    );
        logic [4:0] x, y, so, co, s;
        logic c_run;
        x[0] = test_i ? ta_i[0] : a_i[0];
        x[1] = test_i ? ta_i[1] : (is_i[0] ? a_i[0] : a_i[1]);
        x[2] = test_i ? ta_i[2] : (is_i[1] ? a_i[1] : a_i[2]);
        x[3] = test_i ? ta_i[3] : (is_i[2] ? a_i[2] : a_i[3]);
        x[4] = test_i ? ta_i[4] : a_i[3];
        y[0] = test_i ? tb_i[0] : b_i[0];
        y[1] = test_i ? tb_i[1] : (is_i[0] ? b_i[0] : b_i[1]);
        y[2] = test_i ? tb_i[2] : (is_i[1] ? b_i[1] : b_i[2]);
        y[3] = test_i ? tb_i[3] : (is_i[2] ? b_i[2] : b_i[3]);
        y[4] = test_i ? tb_i[4] : b_i[3];
        so = '0;
        co = '0;
        s  = '0;
        c_run = test_i ? tc_i : 1'b0;
        for (int j = 0; j < 5; j++) begin
            so[j] = se[j] ? sv[j] : (x[j] ^ y[j] ^ c_run);
            co[j] = ce[j] ? cv[j] : ((x[j] & y[j]) | (x[j] & c_run) | (y[j] & c_run));
            c_run = cs_i[j] ? c_run : co[j];
        end
        for (int i = 0; i < 4; i++) begin
            s[i] = ss_i[i] ? so[i+1] : so[i];
        end
        s[4] = cs_i[4] ? co[4] : co[3];
        return {s, co[3:0], so[3:0]};
    endfunction

    always_comb begin
        {bus.s_obs, bus.ct, bus.st} = adder_eval(bus.test, bus.tc_1, bus.ta, bus.tb,
                                                 bus.is, bus.cs, bus.ss, a, b,
                                                 s_en, s_val, c_en, c_val);
    end

    // ---------------- reference model ----------------
    function automatic void tb_vector(input int i, output logic [4:0] va, output logic [4:0] vb,
                                      output logic vc);
        if (i == 8) begin
            va = 5'b01010; vb = 5'b10101; vc = 1'b1;
        end else if (i == 9) begin
            va = 5'b10101; vb = 5'b01010; vc = 1'b0;
        end else begin
            va = (i % 2 == 1) ? 5'b11111 : 5'b00000;
            vb = ((i / 2) % 2 == 1) ? 5'b11111 : 5'b00000;
            vc = ((i / 4) % 2 == 1);
        end
    endfunction

    function automatic logic [4:0] ref_mask(input logic [4:0] se, sv, ce, cv);
        logic [4:0] m;
        logic [4:0] va, vb;
        logic vc, cin, es, ec, os, oc;
        int tot;
        m = '0;
        for (int i = 0; i < NUM_VEC; i++) begin
            tb_vector(i, va, vb, vc);
            cin = vc;
            for (int j = 0; j < 5; j++) begin
                tot = int'(va[j]) + int'(vb[j]) + int'(cin);
                es  = (tot % 2 == 1);
                ec  = (tot >= 2);
                os  = se[j] ? sv[j] : es;
                oc  = ce[j] ? cv[j] : ec;
                if (os != es || oc != ec) m[j] = 1'b1;
                cin = oc;
            end
        end
        return m;
    endfunction

    // {mask, fail, is, cs, ss}
    function automatic logic [17:0] ref_resp(input logic [4:0] m);
        int ones, k;
        logic [2:0] is_e;
        logic [4:0] cs_e;
        logic [3:0] ss_e;
        ones = 0;
        k    = 0;
        for (int j = 0; j < 5; j++) if (m[j]) ones++;
        if (m[3:0] == 4'b0000) return {m, 13'b0};
        if (ones > 1) return {m, 1'b1, 12'b0};
        for (int j = 0; j < 4; j++) if (m[j]) k = j;
        is_e = '0;
        cs_e = '0;
        ss_e = '0;
        for (int j = 0; j < 3; j++) if (j >= k) is_e[j] = 1'b1;
        for (int j = 0; j < 4; j++) if (j >= k) ss_e[j] = 1'b1;
        cs_e[k] = 1'b1;
        cs_e[4] = 1'b1;
        return {m, 1'b0, is_e, cs_e, ss_e};
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_reset_vals();
        check("rst_test", 32'(bus.test), 32'(0));
        check("rst_tc_1", 32'(bus.tc_1), 32'(0));
        check("rst_ta", 32'(bus.ta), 32'(0));
        check("rst_tb", 32'(bus.tb), 32'(0));
        check("rst_is", 32'(bus.is), 32'(0));
        check("rst_cs", 32'(bus.cs), 32'(0));
        check("rst_ss", 32'(bus.ss), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_done", 32'(done), 32'(0));
        check("rst_fault_mask", 32'(fault_mask), 32'(0));
        check("rst_fail", 32'(fail), 32'(0));
        check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    endtask

    // Monitor: one expected outcome is consumed on each rising edge of done.
    always @(negedge clk) begin
        logic [17:0] e;
        int acc;
        if (rst) begin
            done_prev = 1'b0;
        end else begin
            if (done && !done_prev) begin
                if (exp_q.size() == 0 || acc_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_done: done rose with %0d outcomes queued, required >=1",
                             exp_q.size());
                end else begin
                    e   = exp_q.pop_front();
                    acc = acc_q.pop_front();
                    check("fault_mask", 32'(fault_mask), 32'(e[17:13]));
                    check("fail", 32'(fail), 32'(e[12]));
                    check("is", 32'(bus.is), 32'(e[11:9]));
                    check("cs", 32'(bus.cs), 32'(e[8:4]));
                    check("ss", 32'(bus.ss), 32'(e[3:0]));
                    check("test_after_done", 32'(bus.test), 32'(0));
                    check("busy_after_done", 32'(busy), 32'(0));
                    check("done_latency", 32'(cyc - acc), 32'(LATENCY));
                end
            end
            done_prev = done;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic clear_faults();
        s_en = '0; s_val = '0; c_en = '0; c_val = '0;
    endtask

    // kind: 0 sum sa0, 1 sum sa1, 2 carry sa0, 3 carry sa1
    task automatic set_fault(input int slice, input int kind);
        case (kind)
            0: begin s_en[slice] = 1'b1; s_val[slice] = 1'b0; end
            1: begin s_en[slice] = 1'b1; s_val[slice] = 1'b1; end
            2: begin c_en[slice] = 1'b1; c_val[slice] = 1'b0; end
            default: begin c_en[slice] = 1'b1; c_val[slice] = 1'b1; end
        endcase
    endtask

    task automatic launch(input logic [17:0] e, input bit push);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (push) begin
            exp_q.push_back(e);
            acc_q.push_back(cyc);
        end
        check("busy_on_start", 32'(busy), 32'(1));
        check("test_on_start", 32'(bus.test), 32'(1));
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while (!done && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!done) begin
            n_cmp++;
            n_fail++;
            $display("FAIL done_timeout: done=%0b after %0d cycles, required 1", done, t);
            exp_q.delete();
            acc_q.delete();
        end
        @(negedge clk);
    endtask

    task automatic add_check(input logic [3:0] av, input logic [3:0] bv);
        @(negedge clk);
        a = av;
        b = bv;
        #1;
        check("normal_sum", 32'(bus.s_obs), 32'({1'b0, av} + {1'b0, bv}));
    endtask

    task automatic run_case(input logic [17:0] e, input bit add_ok);
        launch(e, 1'b1);
        wait_done();
        if (add_ok) begin
            repeat (4) add_check(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [4:0] m;
        logic [4:0] faulty;
        logic [17:0] e;
        int nf;

        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        clear_faults();
        repeat (3) @(negedge clk);
        check_reset_vals();
        rst = 1'b0;
        @(negedge clk);

        // Fault-free adder.
        run_case(18'b0, 1'b1);

        // Slice 1 sum stuck-at-0, then a=5, b=6 through the repaired adder.
        clear_faults();
        set_fault(1, 0);
        run_case({5'b00010, 1'b0, 3'b110, 5'b10010, 4'b1110}, 1'b1);
        @(negedge clk);
        a = 4'd5;
        b = 4'd6;
        #1;
        check("sum_5_plus_6", 32'(bus.s_obs), 32'(5'b01011));

        // Slice 0 carry stuck-at-1.
        clear_faults();
        set_fault(0, 3);
        run_case({5'b00001, 1'b0, 3'b111, 5'b10001, 4'b1111}, 1'b1);

        // Slice 3 sum stuck-at-1.
        clear_faults();
        set_fault(3, 1);
        run_case({5'b01000, 1'b0, 3'b000, 5'b11000, 4'b1000}, 1'b1);

        // Spare sum stuck-at-1: spare unused, normal configuration.
        clear_faults();
        set_fault(4, 1);
        run_case({5'b10000, 1'b0, 12'b0}, 1'b1);

        // Two faulty slices: not correctable.
        clear_faults();
        set_fault(0, 0);
        set_fault(2, 1);
        run_case({5'b00101, 1'b1, 12'b0}, 1'b0);

        // start pulse while busy must not restart the run.
        clear_faults();
        set_fault(2, 2);
        launch({5'b00100, 1'b0, 3'b100, 5'b10100, 4'b1100}, 1'b1);
        repeat (5) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done();
        repeat (2) add_check(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));

        // Asynchronous reset in the middle of a run.
        clear_faults();
        set_fault(1, 1);
        launch(18'b0, 1'b0);
        repeat (9) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_reset_vals();
        @(negedge clk);
        rst = 1'b0;
        clear_faults();
        run_case(18'b0, 1'b1);

        // Randomized fault sets against the reference model.
        for (int r = 0; r < 12; r++) begin
            clear_faults();
            nf = $urandom_range(0, 2);
            for (int f = 0; f < nf; f++) begin
                set_fault($urandom_range(0, 4), $urandom_range(0, 3));
            end
            m      = ref_mask(s_en, s_val, c_en, c_val);
            e      = ref_resp(m);
            faulty = s_en | c_en;
            run_case(e, !e[12] && ((faulty & ~m) == 5'b00000));
        end

        repeat (4) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL leftover_outcomes: %0d still queued, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
